regfile_wb_arbiter: RTL and testbench

- Owns the single write port (we3/a3/wd3) of the three-ported register file.
- Shares that port between two requesters: the single-cycle ALU writeback (port A) and the multicycle-unit writeback (port B).
- Port B results wait in a small FIFO; a starvation counter guarantees they eventually drain.
- A per-register pending scoreboard lets hazard logic stall readers of registers with outstanding multicycle results.

---
 rtl/regfile_wb_arbiter_if.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Brief    : Writeback port bundle for regfile_wb_arbiter. The stats counters
//            exist only when REGFILE_WB_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_wd;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_wd;
  logic        b_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        stall;
  logic [31:0] busy;
`ifdef REGFILE_WB_STATS_EN
  logic [31:0] conflict_cnt;
  logic [31:0] stall_cnt;
`endif

  modport slave (
    input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, issue_valid, issue_rd,
    output a_ready, b_ready, we3, a3, wd3, stall, busy
`ifdef REGFILE_WB_STATS_EN
    , output conflict_cnt, stall_cnt
`endif
  );

  modport master (
    output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, issue_valid, issue_rd,
    input  a_ready, b_ready, we3, a3, wd3, stall, busy
`ifdef REGFILE_WB_STATS_EN
    , input conflict_cnt, stall_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Shares the register-file write port between the ALU writeback and
//            a FIFO of multicycle results, with starvation stall and a pending
//            scoreboard. REGFILE_WB_STATS_EN adds conflict/stall counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] C_LIMIT = STV_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [4:0]       r_rd_mem [DEPTH];
  logic [31:0]      r_wd_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [STV_W-1:0] r_starve;
  logic [31:0]      r_busy;
  logic [31:0]      w_busy_nxt;

  logic             w_empty;
  logic             w_full;
  logic             w_stall;
  logic             w_push;
  logic             w_pop;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic [4:0]       w_rd;
  logic [31:0]      w_wd;

  // Grant: a stalled pipeline hands the port to the FIFO head; otherwise the
  // ALU wins, and the FIFO only gets idle slots.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == C_DEPTH);
    w_stall = (r_state == ST_STALL);
    w_gnt_b = !reset && !w_empty && (w_stall || !bus.a_valid);
    w_gnt_a = !reset && !w_stall && bus.a_valid;
    w_push  = !reset && bus.b_valid && !w_full;
    w_pop   = w_gnt_b;
    w_rd    = '0;
    w_wd    = '0;
    if (w_gnt_b) begin
      w_rd = r_rd_mem[r_rptr];
      w_wd = r_wd_mem[r_rptr];
    end else if (w_gnt_a) begin
      w_rd = bus.a_rd;
      w_wd = bus.a_wd;
    end
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  assign bus.we3     = (w_gnt_a || w_gnt_b) && (w_rd != 5'd0);
  assign bus.a3      = w_rd;
  assign bus.wd3     = w_wd;
  assign bus.a_ready = !reset && !w_stall;
  assign bus.b_ready = reset || !w_full;
  assign bus.stall   = !reset && w_stall;
  assign bus.busy    = reset ? 32'd0 : r_busy;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wptr] <= bus.b_rd;
      r_wd_mem[r_wptr] <= bus.b_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Saturating at the limit is enough: only reaching it matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != C_LIMIT) begin
      r_starve <= r_starve + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if ((r_starve == C_LIMIT) && (w_count_nxt != '0)) begin
          w_state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (w_count_nxt == '0) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Issue is applied after the writeback clear so a same-cycle set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt_b) begin
      w_busy_nxt[w_rd] = 1'b0;
    end
    if (bus.issue_valid) begin
      w_busy_nxt[bus.issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

`ifdef REGFILE_WB_STATS_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (!w_empty && w_gnt_a && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign bus.conflict_cnt = r_conflict_cnt;
  assign bus.stall_cnt    = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Scoreboard bench: a queue-based model predicts every cycle's
//            outputs; a monitor pops and compares them against the DUT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        a_ready;
    logic        b_ready;
    logic        stall;
    logic [31:0] busy;
    logic [31:0] conflict_cnt;
    logic [31:0] stall_cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [36:0] fifo_m[$];
  int          starve = 0;
  bit          m_stall = 0;
  logic [31:0] m_busy = '0;
  logic [31:0] m_conf = '0;
  logic [31:0] m_stc  = '0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the model's prediction for that cycle.
  task automatic cyc(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] awd,
                     input bit bv, input logic [4:0] brd, input logic [31:0] bwd,
                     input bit iv, input logic [4:0] ird);
    exp_t        e;
    int          sz;
    bit          ga, gb, nstall;
    logic [4:0]  rd;
    logic [31:0] wd;
    @(negedge clk);
    reset           = r;
    bus.a_valid     = av;
    bus.a_rd        = ard;
    bus.a_wd        = awd;
    bus.b_valid     = bv;
    bus.b_rd        = brd;
    bus.b_wd        = bwd;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    sz = fifo_m.size();
    e.conflict_cnt = m_conf;
    e.stall_cnt    = m_stc;
    if (r) begin
      e.we3 = 0; e.a3 = 0; e.wd3 = 0; e.a_ready = 0; e.b_ready = 1; e.stall = 0; e.busy = 0;
      fifo_m.delete();
      starve = 0; m_stall = 0; m_busy = '0; m_conf = '0; m_stc = '0;
    end else begin
      gb = (sz > 0) && (m_stall || !av);
      ga = !m_stall && av;
      rd = '0; wd = '0;
      if (gb) {rd, wd} = fifo_m[0];
      else if (ga) begin rd = ard; wd = awd; end
      e.we3 = (ga || gb) && (rd != 0);
      e.a3 = rd; e.wd3 = wd;
      e.a_ready = !m_stall;
      e.b_ready = (sz < DEPTH);
      e.stall = m_stall;
      e.busy = m_busy;
      if (sz > 0 && ga && m_conf != 32'hFFFF_FFFF) m_conf++;
      if (m_stall && m_stc != 32'hFFFF_FFFF) m_stc++;
      nstall = m_stall || (starve >= LIMIT);
      if (sz == 0 || gb) starve = 0; else starve++;
      if (gb) begin
        if (rd != 0) m_busy[rd] = 1'b0;
        void'(fifo_m.pop_front());
      end
      if (iv && ird != 0) m_busy[ird] = 1'b1;
      if (bv && sz < DEPTH) fifo_m.push_back({brd, bwd});
      m_stall = nstall && (fifo_m.size() > 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit av);
    for (int i = 0; i < n; i++) cyc(0, av, 5'd1, 32'h1000 + i, 0, 0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("we3",     32'(bus.we3),     32'(e.we3));
        check("a3",      32'(bus.a3),      32'(e.a3));
        check("wd3",     bus.wd3,          e.wd3);
        check("a_ready", 32'(bus.a_ready), 32'(e.a_ready));
        check("b_ready", 32'(bus.b_ready), 32'(e.b_ready));
        check("stall",   32'(bus.stall),   32'(e.stall));
        check("busy",    bus.busy,         e.busy);
`ifdef REGFILE_WB_STATS_EN
        check("conflict_cnt", bus.conflict_cnt, e.conflict_cnt);
        check("stall_cnt",    bus.stall_cnt,    e.stall_cnt);
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_wd = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_wd = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
    // Issue then multicycle result for x7
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    cyc(0, 0, 0, 0, 1, 5'd7, 32'hDEADBEEF, 0, 0);
    idle(3, 0);
    // Starvation of a single entry under continuous ALU traffic
    cyc(0, 1, 5'd2, 32'h22, 1, 5'd9, 32'hAA, 0, 0);
    idle(9, 1);
    // Three back-to-back offers into a two-entry FIFO
    cyc(0, 1, 5'd3, 32'h31, 1, 5'd10, 32'hA0, 0, 0);
    cyc(0, 1, 5'd3, 32'h32, 1, 5'd11, 32'hA1, 0, 0);
    cyc(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hA2, 0, 0);
    idle(12, 1);
    // Write to x0 with an attempted issue of x0
    cyc(0, 0, 0, 0, 1, 5'd0, 32'h55, 1, 5'd0);
    idle(3, 0);
    // Reset with two queued entries and a pending register
    cyc(0, 1, 5'd4, 32'h4, 1, 5'd3, 32'h333, 1, 5'd3);
    cyc(0, 1, 5'd4, 32'h5, 1, 5'd6, 32'h666, 0, 0);
    cyc(1, 1, 5'd4, 32'h6, 0, 0, 0, 0, 0);
    idle(6, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 9) < 2), 5'($urandom_range(0, 31)));
    end
    idle(4, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
